// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PIDs, FSM states,
// PID classification and byte-wide CRC step functions.
package usb_pkg;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_DATA2 = 8'h87;
  localparam logic [7:0] PID_MDATA = 8'h0F;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_NYET  = 8'h96;

  localparam logic [1:0] RX_EVT_ERR = 2'b11;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [4:0]  CRC5_RES   = 5'h0C;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_RES  = 16'h800D;

  typedef enum logic [2:0] {
    S_IDLE, S_TURN, S_PID, S_TOK1,
    S_TOK2, S_DATA, S_HS, S_DROP
  } state_t;

  typedef enum logic [2:0] {
    K_BAD, K_TOK, K_DATA, K_HS, K_OTHER
  } pid_kind_t;

  function automatic pid_kind_t pid_kind(
    input logic [7:0] p
  );
    pid_kind_t k;
    k = K_OTHER;
    unique case (1'b1)
      (p[3:0] != ~p[7:4]): k = K_BAD;
      (p == PID_OUT || p == PID_IN ||
       p == PID_SETUP): k = K_TOK;
      (p == PID_DATA0 || p == PID_DATA1 ||
       p == PID_DATA2 || p == PID_MDATA):
        k = K_DATA;
      (p == PID_ACK || p == PID_NAK ||
       p == PID_STALL || p == PID_NYET):
        k = K_HS;
      default: k = K_OTHER;
    endcase
    return k;
  endfunction

  // Bits enter LSB first, as on the wire.
  function automatic logic [4:0] crc5_byte(
    input logic [4:0] c,
    input logic [7:0] d
  );
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[3:0], 1'b0} ^
          ((d[i] ^ r[4]) ? CRC5_POLY : 5'h00);
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[14:0], 1'b0} ^
          ((d[i] ^ r[15]) ? CRC16_POLY : 16'h0);
    return r;
  endfunction

endpackage

// File: rtl/usb_rx_packet_demux_if.sv
// ULPI receive-direction bus: DIR, NXT, DATA.
// master = PHY side (drives), slave = decoder side.
interface usb_rx_packet_demux_if;
  logic       USB_DIR;
  logic       USB_NXT;
  logic [7:0] USB_DATA;

  modport master (
    output USB_DIR, USB_NXT, USB_DATA
  );
  modport slave (
    input USB_DIR, USB_NXT, USB_DATA
  );
endinterface

// File: rtl/usb_rx_crc.sv
// Byte-wide CRC5/CRC16 residual accumulator.
// Ports: clk, rst_n, clr, en, din -> ok5, ok16.
module usb_rx_crc
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic       ok5,
  output logic       ok16
);

  logic [4:0]  c5;
  logic [15:0] c16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c5  <= CRC5_INIT;
      c16 <= CRC16_INIT;
    end else if (clr) begin
      c5  <= CRC5_INIT;
      c16 <= CRC16_INIT;
    end else if (en) begin
      c5  <= crc5_byte(c5, din);
      c16 <= crc16_byte(c16, din);
    end
  end

  assign ok5  = (c5 == CRC5_RES);
  assign ok16 = (c16 == CRC16_RES);

endmodule

// File: rtl/usb_rx_packet_demux.sv
// ULPI RX packet decoder with N_EP-way data demux.
// Ports: USB_CLKIN, NRST, ulpi (slave), dev_addr ->
//   pid_o, token_o, token_ep_o, token_strb, data_o,
//   data_o_strb/end/fail[N_EP], hs_strb.
// Option: USB_RX_CRC_EN enables CRC5/CRC16 checking.
module usb_rx_packet_demux
  import usb_pkg::*;
#(
  parameter int N_EP    = 4,
  parameter int MAX_PKT = 1026
) (
  input  logic                USB_CLKIN,
  input  logic                NRST,
  usb_rx_packet_demux_if.slave ulpi,
  input  logic [6:0]          dev_addr,
  output logic [7:0]          pid_o,
  output logic [23:0]         token_o,
  output logic [3:0]          token_ep_o,
  output logic                token_strb,
  output logic [7:0]          data_o,
  output logic [N_EP-1:0]     data_o_strb,
  output logic [N_EP-1:0]     data_o_end,
  output logic [N_EP-1:0]     data_o_fail,
  output logic                hs_strb
);

  localparam int CW = $clog2(MAX_PKT + 1);

  state_t          st;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [7:0]      b1;
  logic [7:0]      b2;
  logic            addr_ok;
  logic            tok_seen;
  logic            route;
  logic [N_EP-1:0] ch_oh;
  logic            ok5;
  logic            ok16;
  logic            dir;
  logic            nxt;
  logic [7:0]      d;
  pid_kind_t       kind;

  assign dir  = ulpi.USB_DIR;
  assign nxt  = ulpi.USB_NXT;
  assign d    = ulpi.USB_DATA;
  assign kind = pid_kind(d);

  assign cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;
  assign ch_oh  = route ? (N_EP'(1) << token_ep_o)
                        : '0;

`ifdef USB_RX_CRC_EN
  logic crc_clr;
  logic crc_en;

  assign crc_clr = (st == S_PID);
  assign crc_en  = dir && nxt &&
                   (st == S_TOK1 || st == S_TOK2 ||
                    st == S_DATA);

  usb_rx_crc u_crc (
    .clk  (USB_CLKIN),
    .rst_n(NRST),
    .clr  (crc_clr),
    .en   (crc_en),
    .din  (d),
    .ok5  (ok5),
    .ok16 (ok16)
  );
`else
  assign ok5  = 1'b1;
  assign ok16 = 1'b1;
`endif

  always_ff @(posedge USB_CLKIN or negedge NRST) begin
    if (!NRST) begin
      st          <= S_IDLE;
      cnt         <= '0;
      b1          <= '0;
      b2          <= '0;
      addr_ok     <= 1'b0;
      tok_seen    <= 1'b0;
      route       <= 1'b0;
      pid_o       <= '0;
      token_o     <= '0;
      token_ep_o  <= '0;
      token_strb  <= 1'b0;
      data_o      <= '0;
      data_o_strb <= '0;
      data_o_end  <= '0;
      data_o_fail <= '0;
      hs_strb     <= 1'b0;
    end else begin
      token_strb  <= 1'b0;
      hs_strb     <= 1'b0;
      data_o_strb <= '0;
      data_o_end  <= '0;
      data_o_fail <= '0;
      unique case (st)
        S_IDLE: if (dir) st <= S_TURN;
        S_TURN: st <= dir ? S_PID : S_IDLE;
        S_PID: begin
          if (!dir) st <= S_IDLE;
          else if (nxt) begin
            cnt <= '0;
            if (kind != K_BAD) pid_o <= d;
            unique case (kind)
              K_TOK:  st <= S_TOK1;
              K_DATA: begin
                st    <= S_DATA;
                route <= tok_seen &&
                         (32'(token_ep_o) < N_EP);
              end
              K_HS:   st <= S_HS;
              default: st <= S_DROP;
            endcase
          end
        end
        S_TOK1: begin
          if (!dir) st <= S_IDLE;
          else if (nxt) begin
            b1  <= d;
            cnt <= CW'(1);
            st  <= S_TOK2;
          end
        end
        S_TOK2: begin
          if (!dir) begin
            st <= S_IDLE;
            if (cnt == CW'(2) && addr_ok && ok5) begin
              token_o    <= {b2, b1, pid_o};
              token_ep_o <= {b2[2:0], b1[7]};
              token_strb <= 1'b1;
              tok_seen   <= 1'b1;
            end
          end else if (nxt) begin
            if (cnt == CW'(1)) begin
              b2      <= d;
              addr_ok <= (b1[6:0] == dev_addr);
            end
            cnt <= cnt_nx;
          end
        end
        S_DATA: begin
          if (!dir) begin
            st <= S_IDLE;
            if (ok16) data_o_end  <= ch_oh;
            else      data_o_fail <= ch_oh;
          end else if (nxt) begin
            if (cnt == CW'(MAX_PKT)) begin
              data_o_fail <= ch_oh;
              st          <= S_DROP;
            end else begin
              data_o      <= d;
              data_o_strb <= ch_oh;
              cnt         <= cnt_nx;
            end
          end else if (d[5:4] == RX_EVT_ERR) begin
            data_o_fail <= ch_oh;
            st          <= S_DROP;
          end
        end
        S_HS: begin
          if (!dir) begin
            hs_strb <= 1'b1;
            st      <= S_IDLE;
          end
        end
        S_DROP: if (!dir) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_demux.sv
// Bench for usb_rx_packet_demux: directed ULPI packets,
// per-cycle compare against a packet-level model.
module tb_usb_rx_packet_demux;
  import usb_pkg::*;

  localparam int N_EP    = 4;
  localparam int MAX_PKT = 1026;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      dev_addr = '0;
  logic [7:0]      pid_o;
  logic [23:0]     token_o;
  logic [3:0]      token_ep_o;
  logic            token_strb;
  logic [7:0]      data_o;
  logic [N_EP-1:0] data_o_strb;
  logic [N_EP-1:0] data_o_end;
  logic [N_EP-1:0] data_o_fail;
  logic            hs_strb;

  usb_rx_packet_demux_if ulpi ();

  usb_rx_packet_demux #(
    .N_EP(N_EP), .MAX_PKT(MAX_PKT)
  ) dut (
    .USB_CLKIN  (clk),
    .NRST       (rst_n),
    .ulpi       (ulpi),
    .dev_addr   (dev_addr),
    .pid_o      (pid_o),
    .token_o    (token_o),
    .token_ep_o (token_ep_o),
    .token_strb (token_strb),
    .data_o     (data_o),
    .data_o_strb(data_o_strb),
    .data_o_end (data_o_end),
    .data_o_fail(data_o_fail),
    .hs_strb    (hs_strb)
  );

  always #8 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [N_EP-1:0] e_strb[int];
  logic [N_EP-1:0] e_end[int];
  logic [N_EP-1:0] e_fail[int];
  logic [7:0]      e_data[int];
  logic [7:0]      e_pid[int];
  logic [23:0]     e_tok[int];
  bit              e_hs[int];

  logic [23:0] m_tok = '0;
  logic [7:0]  m_pid = '0;
  bit          tok_seen = 1'b0;
  logic [3:0]  m_ep = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (e_tok.exists(cyc)) m_tok = e_tok[cyc];
      if (e_pid.exists(cyc)) m_pid = e_pid[cyc];
      chk("data_o_strb", 32'(data_o_strb),
          e_strb.exists(cyc) ? 32'(e_strb[cyc]) : 0);
      chk("data_o_end", 32'(data_o_end),
          e_end.exists(cyc) ? 32'(e_end[cyc]) : 0);
      chk("data_o_fail", 32'(data_o_fail),
          e_fail.exists(cyc) ? 32'(e_fail[cyc]) : 0);
      if (e_data.exists(cyc))
        chk("data_o", 32'(data_o), 32'(e_data[cyc]));
      chk("token_strb", 32'(token_strb),
          32'(e_tok.exists(cyc)));
      chk("hs_strb", 32'(hs_strb),
          32'(e_hs.exists(cyc)));
      chk("token_o", 32'(token_o), 32'(m_tok));
      chk("token_ep_o", 32'(token_ep_o),
          32'({m_tok[18:16], m_tok[15]}));
      chk("pid_o", 32'(pid_o), 32'(m_pid));
    end
  end

  // Field value as placed in byte2[7:3].
  function automatic logic [4:0] crc5(
    input logic [10:0] v);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++)
      c = {c[3:0], 1'b0} ^
          ((v[i] ^ c[4]) ? 5'h05 : 5'h00);
    return {~c[0], ~c[1], ~c[2], ~c[3], ~c[4]};
  endfunction

  function automatic bit tok_crc_ok(
    input logic [7:0] b1, input logic [7:0] b2);
`ifdef USB_RX_CRC_EN
    return crc5({b2[2:0], b1}) == b2[7:3];
`else
    return b1 == b1 && b2 == b2;
`endif
  endfunction

  function automatic bit data_crc_ok(
    input logic [7:0] q[$]);
`ifdef USB_RX_CRC_EN
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[k])
      for (int i = 0; i < 8; i++)
        c = {c[14:0], 1'b0} ^
            ((q[k][i] ^ c[15]) ? 16'h8005 : 16'h0);
    return c == 16'h800D;
`else
    return q.size() >= 0;
`endif
  endfunction

  task automatic drive(input bit dir, input bit nxt,
                       input logic [7:0] dv,
                       output int s);
    @(posedge clk);
    #1;
    ulpi.USB_DIR  = dir;
    ulpi.USB_NXT  = nxt;
    ulpi.USB_DATA = dv;
    s = cyc;
  endtask

  task automatic post();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] pid,
                      input logic [7:0] pl[$],
                      input int err_at);
    int s;
    bit good, tok, dat, hs, route, failed;
    logic [N_EP-1:0] oh;
    drive(1, 0, 8'h00, s);
    drive(1, 0, 8'h10, s);
    drive(1, 1, pid, s);
    good = (pid[3:0] == ~pid[7:4]);
    tok = good && (pid inside {8'hE1, 8'h69, 8'h2D});
    dat = good && (pid inside
          {8'hC3, 8'h4B, 8'h87, 8'h0F});
    hs = good && (pid inside
          {8'hD2, 8'h5A, 8'h1E, 8'h96});
    if (good) e_pid[s+1] = pid;
    route = dat && tok_seen && (int'(m_ep) < N_EP);
    oh = route ? (N_EP'(1) << m_ep) : '0;
    failed = 0;
    for (int i = 0; i <= pl.size(); i++) begin
      if (i == err_at && !failed) begin
        drive(1, 0, 8'h30, s);
        if (dat) begin
          e_fail[s+1] = oh;
          failed = 1;
        end
      end
      if (i == pl.size()) break;
      drive(1, 1, pl[i], s);
      if (dat && !failed) begin
        if (i + 1 > MAX_PKT) begin
          e_fail[s+1] = oh;
          failed = 1;
        end else if (route) begin
          e_strb[s+1] = oh;
          e_data[s+1] = pl[i];
        end
      end
    end
    drive(0, 0, 8'h00, s);
    if (dat && !failed) begin
      if (data_crc_ok(pl)) e_end[s+1] = oh;
      else                 e_fail[s+1] = oh;
    end
    if (tok && pl.size() == 2 &&
        pl[0][6:0] == dev_addr &&
        tok_crc_ok(pl[0], pl[1])) begin
      e_tok[s+1] = {pl[1], pl[0], pid};
      tok_seen = 1;
      m_ep = {pl[1][2:0], pl[0][7]};
    end
    if (hs) e_hs[s+1] = 1;
  endtask

  function automatic logic [15:0] tokb(
    input logic [6:0] a, input logic [3:0] ep);
    logic [7:0] b1, b2;
    b1 = {ep[0], a};
    b2 = {crc5({ep, a}), ep[3:1]};
    return {b2, b1};
  endfunction

  initial begin
    logic [7:0]  q[$];
    logic [15:0] tb2;
    int s;
    ulpi.USB_DIR  = 0;
    ulpi.USB_NXT  = 0;
    ulpi.USB_DATA = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst pid_o", 32'(pid_o), 0);
    chk("rst token_o", 32'(token_o), 0);
    chk("rst token_ep_o", 32'(token_ep_o), 0);
    chk("rst token_strb", 32'(token_strb), 0);
    chk("rst data_o", 32'(data_o), 0);
    chk("rst data_o_strb", 32'(data_o_strb), 0);
    chk("rst end_fail",
        32'({data_o_end, data_o_fail}), 0);
    chk("rst hs_strb", 32'(hs_strb), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk_en = 1;

    // token accept, address 0
    dev_addr = 7'h00;
    q = {8'h00, 8'h10};
    send(8'h2D, q, -1);
    post();
    chk("lit tok strb", 32'(token_strb), 1);
    chk("lit tok", 32'(token_o), 32'h10002D);
    chk("lit tok ep", 32'(token_ep_o), 0);

    // address filter
    dev_addr = 7'h05;
    send(8'h2D, q, -1);
    post();
    chk("lit filt strb", 32'(token_strb), 0);
    chk("lit filt tok", 32'(token_o), 32'h10002D);

    // OUT to ep 2, then 250-byte DATA0
    tb2 = tokb(7'h05, 4'd2);
    q = {tb2[7:0], tb2[15:8]};
    send(8'hE1, q, -1);
    post();
    chk("lit ep2", 32'(token_ep_o), 2);
    q = {};
    for (int i = 0; i < 250; i++) q.push_back(8'(i));
    send(8'hC3, q, -1);
    post();
`ifndef USB_RX_CRC_EN
    chk("lit end ep2", 32'(data_o_end), 32'h4);
`endif

    // handshake
    q = {};
    send(8'hD2, q, -1);
    post();
    chk("lit hs", 32'(hs_strb), 1);
    chk("lit hs pid", 32'(pid_o), 32'hD2);

    // malformed PID
    q = {8'h01, 8'h02};
    send(8'h2E, q, -1);

    // DIR falls while waiting for PID
    drive(1, 0, 8'h00, s);
    drive(1, 0, 8'h10, s);
    drive(0, 0, 8'h00, s);

    // RxError after 10 bytes
    q = {};
    for (int i = 0; i < 10; i++)
      q.push_back(8'(8'hA0 + i));
    send(8'h4B, q, 10);
    post();
    chk("lit err pid", 32'(pid_o), 32'h4B);

    // token with 3 bytes is rejected
    tb2 = tokb(7'h05, 4'd1);
    q = {tb2[7:0], tb2[15:8], 8'h00};
    send(8'h69, q, -1);

    // ep 5 is out of range: silent DATA
    tb2 = tokb(7'h05, 4'd5);
    q = {tb2[7:0], tb2[15:8]};
    send(8'hE1, q, -1);
    q = {8'h11, 8'h22, 8'h33};
    send(8'hC3, q, -1);

    // ep 3 then overflow
    tb2 = tokb(7'h05, 4'd3);
    q = {tb2[7:0], tb2[15:8]};
    send(8'hE1, q, -1);
    q = {};
    for (int i = 0; i < MAX_PKT + 1; i++)
      q.push_back(8'(i * 7));
    send(8'h4B, q, -1);

    // reset mid-packet
    post();
    chk_en = 0;
    drive(1, 0, 8'h00, s);
    drive(1, 0, 8'h10, s);
    drive(1, 1, 8'hC3, s);
    drive(1, 1, 8'hAA, s);
    drive(1, 1, 8'hBB, s);
    @(posedge clk);
    #2;
    chk("lit pre-rst strb", 32'(data_o_strb), 32'h8);
    chk("lit pre-rst data", 32'(data_o), 32'hBB);
    rst_n = 0;
    #1;
    chk("mid-rst strb", 32'(data_o_strb), 0);
    chk("mid-rst data", 32'(data_o), 0);
    chk("mid-rst tok", 32'(token_o), 0);
    chk("mid-rst pid", 32'(pid_o), 0);
    chk("mid-rst ep", 32'(token_ep_o), 0);
    ulpi.USB_DIR = 0;
    ulpi.USB_NXT = 0;
    e_strb.delete(); e_end.delete();
    e_fail.delete(); e_data.delete();
    e_pid.delete();  e_tok.delete();
    e_hs.delete();
    tok_seen = 0; m_ep = '0;
    m_tok = '0;   m_pid = '0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk_en = 1;

    // no token since reset: silent
    q = {8'h01, 8'h02};
    send(8'hC3, q, -1);
    tb2 = tokb(7'h05, 4'd1);
    q = {tb2[7:0], tb2[15:8]};
    send(8'h2D, q, -1);
    q = {8'h5A, 8'hA5, 8'h3C};
    send(8'h87, q, -1);
    post();
`ifndef USB_RX_CRC_EN
    chk("lit end ep1", 32'(data_o_end), 32'h2);
`endif

`ifdef USB_RX_CRC_EN
    q = {8'h00, 8'h00};
    send(8'hC3, q, -1);
    post();
    chk("lit crc good", 32'(data_o_end), 32'h2);
    q = {8'h01, 8'h00, 8'h00};
    send(8'hC3, q, -1);
    post();
    chk("lit crc bad", 32'(data_o_fail), 32'h2);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_demux.md
# usb_rx_packet_demux

Parametrised ULPI receive-side packet decoder and endpoint demultiplexer. It replaces the single-channel token/data receive path of `usb_handshake_multiplexer` with N endpoint channels. It watches the ULPI receive bus, decodes PID, token and data packets, and filters tokens against the assigned device address. Data bytes are routed to the channel selected by the endpoint of the last accepted token, with per-channel strobe, end and fail signalling. The block sits between the ULPI PHY pins (receive direction only) and the endpoint/control logic.

## Interface
- `N_EP`, default 4, number of endpoint channels (1..16).
- `MAX_PKT`, default 1026, maximum bytes after the PID, including CRC16; longer packets fail.
- `USB_CLKIN`, in, 1, 60 MHz ULPI clock; all logic runs on its rising edge.
- `NRST`, in, 1, reset; asynchronous assert, active-low.
- `USB_DIR`, in, 1, ULPI DIR.
- `USB_NXT`, in, 1, ULPI NXT.
- `USB_DATA`, in, 8, ULPI data bus, sampled only while DIR=1.
- `dev_addr`, in, 7, assigned device address; sampled at the token's last byte.
- `pid_o`, out, 8, PID of the current/last valid packet.
- `token_o`, out, 24, {byte2, byte1, PID} of the last accepted token.
- `token_ep_o`, out, 4, endpoint field of `token_o`.
- `token_strb`, out, 1, one-cycle pulse when a token is accepted.
- `data_o`, out, 8, shared data byte for all channels.
- `data_o_strb`, out, N_EP, per-channel byte-valid pulse.
- `data_o_end`, out, N_EP, per-channel good-end pulse.
- `data_o_fail`, out, N_EP, per-channel abort pulse.
- `hs_strb`, out, 1, one-cycle pulse when an ACK, NAK, STALL or NYET handshake PID is received; `pid_o` holds that PID.

## Operation
- Every output resets to 0, and the FSM resets to IDLE.
- ULPI byte classes while DIR=1, after the turnaround cycle:
  - NXT=1: packet byte.
  - NXT=0: RX CMD.
- FSM states:
  - IDLE: DIR rises → TURN.
  - TURN: the turnaround cycle; data is ignored. If DIR=1 → PID, else → IDLE.
  - PID: the first packet byte is checked with `pid[3:0] == ~pid[7:4]`. On a failed check → DROP. On a token PID (OUT/IN/SETUP) → TOK1. On DATA0/1/2/MDATA → DATA. On a handshake PID → HS. Other PIDs → DROP. RX CMD bytes here are ignored.
  - TOK1 → TOK2: capture byte1, then byte2.
  - TOK2: wait for DIR to fall. On the fall, accept only if exactly 2 bytes followed the PID and `byte1[6:0] == dev_addr`. Accepted tokens latch `token_o`, `token_ep_o = {byte2[2:0], byte1[7]}` and pulse `token_strb`.
  - DATA: each packet byte is registered to `data_o`, and `data_o_strb[ch]` pulses, where ch = latched `token_ep_o`. `pid_o` updates at the PID byte.
  - HS: pulse `hs_strb` on DIR fall.
  - DROP: ignore everything until DIR falls → IDLE.
- Channel validity: DATA packets are routed only if a token has been accepted since reset and `token_ep_o < N_EP`. Otherwise the packet is consumed silently, with no strobes.
- DATA end: when DIR falls, `data_o_end[ch]` pulses.
- DATA fail: during DATA, any of the following pulses `data_o_fail[ch]` and returns to IDLE or DROP:
  - an RX CMD with RxEvent bits [5:4] = 2'b11 (RxError);
  - a byte count exceeding `MAX_PKT`.
- Only one of end or fail ever pulses per packet.
- Byte counter: `$clog2(MAX_PKT+1)` bits, saturating.
- DIR falling in TURN or PID → IDLE with no outputs.
- Reset mid-packet: all pulses clear immediately and no end or fail is issued.

## Timing
- Packet byte in cycle t (NXT=1) → `data_o` valid and `data_o_strb` high in cycle t+1.
- DIR low first sampled in cycle t → `token_strb`, `data_o_end` or `hs_strb` high in cycle t+1, for one cycle.
- Error RX CMD in cycle t → `data_o_fail` high in cycle t+1.
- Back-to-back packets: a new DIR rise in the cycle after the fall is handled normally. The end pulse and the new TURN may overlap.
- `token_o`, `token_ep_o` and `pid_o` hold until overwritten.

## Configuration
- `USB_RX_CRC_EN`:
  - Defined: CRC5 is checked over the token's 11 bits, and CRC16 over all DATA bytes after the PID.
    - A bad CRC5 rejects the token (no `token_strb`).
    - A bad CRC16 residual (≠ 16'h800D) turns the end pulse into a `data_o_fail` pulse in the same cycle.
  - Undefined: no CRC logic; all length- and address-valid tokens are accepted, and DATA always ends with `data_o_end`.
  - In both builds, CRC bytes are still delivered on `data_o`.

## Structure
- Shared package `usb_pkg`:
  - PID constants;
  - PID type predicates;
  - FSM state enum;
  - RxEvent error code 2'b11;
  - CRC5 polynomial 5'h05, CRC16 polynomial 16'h8005, residual constants.
- Sub-module `usb_rx_crc`: byte-wide CRC5/CRC16 accumulator with clear, enable and ok flag. It is instantiated only under `USB_RX_CRC_EN`.

## Test plan
- Token accept: dev_addr=0, bytes 2D 00 10 then DIR low → `token_strb`=1 one cycle, `token_o`=24'h10002D, `token_ep_o`=0.
- Address filter: dev_addr=7'h05, same token → no `token_strb`; `token_o` unchanged.
- Routing, N_EP=4: accept an OUT token to ep 2, then DATA0 C3 followed by 250 incrementing bytes.
  - Each byte appears on `data_o` one cycle later with `data_o_strb`=4'b0100.
  - After DIR falls, `data_o_end`=4'b0100.
- RxError abort: DATA0 with 10 bytes, then RX CMD 0x30 with NXT=0 → `data_o_fail`=4'b0100 one cycle later; no end pulse.
- CRC (macro on): C3 00 00 → `data_o_end` pulses; C3 01 00 00 → `data_o_fail` instead.
- Overflow and reset: MAX_PKT+1 bytes → fail at byte MAX_PKT+1. Asserting NRST mid-packet → all outputs 0 immediately, and the next packet decodes correctly.
